// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Core opcodes that reach this block
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    // Default array geometry
    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DEPTH  = 4096;
    localparam int DMEM_DATA_W = 32;

    // Initial value of the WAIT countdown for a given read latency.
    // A latency of 1 never enters WAIT, so its value is irrelevant.
    function automatic logic [3:0] lat_init(input int lat);
        logic [3:0] v;
        v = 4'd0;
        if (lat > 1) begin
            v = 4'(lat - 2);
        end
        return v;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit data RAM with write enable and registered read port.
// Latency: write commits at the clock edge; read data valid one edge after re.
// Backpressure: none; rdata holds its last value while re is low.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Storage write and read-register update; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder owning the data RAM; one transaction outstanding at a time.
// Latency: load accept -> rsp_valid after READ_LAT edges; store accept -> ack after 1 edge.
// Backpressure: rsp_ready low holds RESP and all response fields; req_ready stays low.
// Optional: define DMEM_BOUNDS_CHECK_EN to flag and suppress accesses with req_addr >= DEPTH.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] LAT_INIT = lat_init(READ_LAT);
    localparam bit         FAST_RD  = (READ_LAT == 1);

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic [3:0]        lat_cnt;
    logic [3:0]        lat_cnt_nxt;

    // Transaction context held across WAIT/RESP
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              rd_sel_q;   // response data comes from the RAM read register
    logic [31:0]       rdata_q;    // echoed store data, or zero for reset / bad load

    logic              accept;
    logic              capture;
    logic              oor;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [31:0]       arr_rdata;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oor     = (req_addr >= 32'(DEPTH));
    assign rsp_err = err_q;
`else
    logic unused_addr_hi;
    assign oor            = 1'b0;
    assign rsp_err        = 1'b0;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
`endif

    // Reset is folded in so a request presented during reset cannot write the RAM
    assign accept  = (state == IDLE) && req_valid && rst_n;
    assign capture = (state == WAIT) && (lat_cnt == 4'd0);

    // Writes happen at the accept edge; reads either at accept (latency 1) or at the end of WAIT
    assign arr_we   = accept && req_we && !oor;
    assign arr_re   = (accept && !req_we && !oor && FAST_RD) || (capture && !err_q);
    assign arr_addr = (state == WAIT) ? addr_q : req_addr[ADDR_W-1:0];

    // Response data is a mux of two registers, so it never depends on live inputs
    assign rsp_rdata = rd_sel_q ? arr_rdata : rdata_q;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // FSM state and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Next-state logic and handshake outputs decoded from state only
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_we || FAST_RD) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt   = WAIT;
                        lat_cnt_nxt = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transaction context capture at accept and at the end of the read wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (accept) begin
            addr_q <= req_addr[ADDR_W-1:0];
            err_q  <= oor;
            if (req_we) begin
                rdata_q  <= req_wdata;
                rd_sel_q <= 1'b0;
            end else if (FAST_RD) begin
                rdata_q  <= 32'd0;
                rd_sel_q <= !oor;
            end
        end else if (capture) begin
            rdata_q  <= 32'd0;
            rd_sel_q <= !err_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: READ_LAT=2 main instance plus a READ_LAT=1 throughput instance.
// Latency: expectations are derived from a reference memory model and a response queue.
// Backpressure: exercised by holding rsp_ready low with req_valid held high.
module tb_dmem_responder;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        r1_valid, r1_we, r1_rsp_ready;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_req_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_rsp_rdata;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cycle  = 0;

    logic [31:0] ref_mem [4096];
    logic [31:0] sb_dat [$];
    logic        sb_err [$];
    logic [31:0] sb1    [$];

    always #5 clk = ~clk;

    // Free-running cycle count used for accept spacing
    always @(posedge clk) cycle <= cycle + 1;

    dmem_responder #(.READ_LAT(RL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.READ_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r1_valid),
        .req_ready (r1_req_ready),
        .req_we    (r1_we),
        .req_addr  (r1_addr),
        .req_wdata (r1_wdata),
        .rsp_valid (r1_rsp_valid),
        .rsp_ready (r1_rsp_ready),
        .rsp_rdata (r1_rsp_rdata),
        .rsp_err   (r1_rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, act, exp, cycle);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction on the main instance; stall>0 holds rsp_ready low and req_valid high
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall);
        logic        e;
        logic [31:0] d;
        logic [31:0] held;
        int          cyc;
        int          lat;
        e = BC && (addr >= 32'd4096);
        if (we) begin
            d = wdata;
            if (!e) ref_mem[addr[11:0]] = wdata;
        end else begin
            d = e ? 32'd0 : ref_mem[addr[11:0]];
        end
        lat = we ? 1 : RL;
        sb_dat.push_back(d);
        sb_err.push_back(e);

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (stall == 0);
        check_eq("req_ready_idle", req_ready, 1);
        tick;
        if (stall == 0) req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        check_eq("rsp_latency", cyc, lat);
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_rdata", rsp_rdata, sb_dat.pop_front());
        check_eq("rsp_err", rsp_err, sb_err.pop_front());
        held = rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            tick;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_rdata", rsp_rdata, held);
            check_eq("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        check_eq("post_rsp_valid", rsp_valid, 0);
        check_eq("post_req_ready", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc [8];
        int          cyc;
        logic [31:0] a1, d1;

        // Reset held with a store presented
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'd5;
        req_wdata    = 32'hBAD0_0001;
        rsp_ready    = 1'b1;
        r1_valid     = 1'b0;
        r1_we        = 1'b0;
        r1_addr      = 32'd0;
        r1_wdata     = 32'd0;
        r1_rsp_ready = 1'b1;
        repeat (3) tick;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick;

        // Store then load, backpressured load, edge addresses
        do_req(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 32'd5, 32'd0, 0);
        do_req(1'b0, 32'd5, 32'd0, 3);
        do_req(1'b1, 32'd0, 32'h0000_0001, 0);
        do_req(1'b1, 32'd4095, 32'hFFFF_0FFF, 0);
        do_req(1'b0, 32'd4095, 32'd0, 0);
        do_req(1'b0, 32'd0, 32'd0, 0);

        // Reset with a store presented must not write
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd5;
        req_wdata = 32'hBAD0_BAD0;
        rst_n     = 1'b0;
        repeat (2) tick;
        check_eq("rst2_rsp_valid", rsp_valid, 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick;
        do_req(1'b0, 32'd5, 32'd0, 0);

        // Out-of-range store, then load of the aliased address
        do_req(1'b1, 32'h0000_1005, 32'h1234_5678, 0);
        do_req(1'b0, 32'd5, 32'd0, 0);
        do_req(1'b0, 32'h0000_1005, 32'd0, 0);

        // Reset during WAIT discards the load; earlier store stays committed
        do_req(1'b1, 32'd7, 32'hA5A5_A5A5, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd9;
        tick;
        req_valid = 1'b0;
        check_eq("wait_busy", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_req_ready", req_ready, 1);
        repeat (2) tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check_eq("midrst_no_rsp", rsp_valid, 0);
        end
        check_eq("midrst_rdata", rsp_rdata, 0);
        do_req(1'b0, 32'd7, 32'd0, 0);

        // READ_LAT=1 throughput: four stores then four loads, req_valid held high
        for (int i = 0; i < 8; i++) begin
            a1 = 32'd100 + 32'(i % 4);
            d1 = 32'hC0DE_0000 + 32'(i % 4) * 32'h0101_0101;
            r1_valid = 1'b1;
            r1_we    = (i < 4);
            r1_addr  = a1;
            r1_wdata = (i < 4) ? d1 : 32'hFFFF_FFFF;
            sb1.push_back(d1);
            cyc = 0;
            while (!r1_req_ready && cyc < 10) begin
                tick;
                cyc++;
            end
            acc[i] = cycle;
            tick;
            check_eq("tp_rsp_valid", r1_rsp_valid, 1);
            check_eq("tp_rdata", r1_rsp_rdata, sb1.pop_front());
            if (i > 0) check_eq("tp_spacing", acc[i] - acc[i-1], 2);
        end
        r1_valid = 1'b0;
        tick;
        check_eq("tp_idle", r1_req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
